// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared types and constants for the data-memory arbiter.
package dmem_arb_pkg;
  localparam int NUM_REQ = 2;
  localparam int WORD_BYTES = 4;
  typedef enum logic [1:0] {IDLE, ACCESS, RMW_WRITE} dmem_arb_state_t;
  typedef struct packed {
    logic                    we;
    logic [WORD_BYTES-1:0]   be;
    logic [31:0]             addr;
    logic [WORD_BYTES*8-1:0] wdata;
  } dmem_req_t;
endpackage

// File: rtl/dmem_be_merge.sv
// dmem_be_merge: byte-lane merge, lane k taken from i_new when i_be[k] is set, else from i_old.
module dmem_be_merge
  import dmem_arb_pkg::*;
(
  input  logic [WORD_BYTES*8-1:0] i_old,
  input  logic [WORD_BYTES*8-1:0] i_new,
  input  logic [WORD_BYTES-1:0]   i_be,
  output logic [WORD_BYTES*8-1:0] o_merged
);
  for (genvar k = 0; k < WORD_BYTES; k++) begin : g_lane
    assign o_merged[8*k +: 8] = i_be[k] ? i_new[8*k +: 8] : i_old[8*k +: 8];
  end
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-requester valid/ready arbiter for a full-word-write data memory, with RMW for partial stores.
// Define DMEM_ARB_RR_EN for round-robin arbitration; otherwise requester 0 has fixed priority.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic [NUM_REQ-1:0]                   req_valid_i,
  output logic [NUM_REQ-1:0]                   req_ready_o,
  input  logic [NUM_REQ-1:0]                   req_we_i,
  input  logic [NUM_REQ-1:0][WORD_BYTES-1:0]   req_be_i,
  input  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]   req_addr_i,
  input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]   req_wdata_i,
  output logic [NUM_REQ-1:0]                   rsp_valid_o,
  output logic [DATA_WIDTH-1:0]                rsp_rdata_o,
  output logic                                 mem_write_en_o,
  output logic [ADDR_WIDTH-1:0]                mem_addr_o,
  output logic [DATA_WIDTH-1:0]                mem_write_data_o,
  input  logic [DATA_WIDTH-1:0]                mem_read_data_i
);
  dmem_arb_state_t r_state, w_next;
  dmem_req_t r_req;
  logic r_grant, w_win, w_hs, w_partial;
  logic [DATA_WIDTH-1:0] r_old, r_rdata, w_merged;
  logic [NUM_REQ-1:0] r_rsp;
`ifdef DMEM_ARB_RR_EN
  logic r_last;
  assign w_win = &req_valid_i ? ~r_last : req_valid_i[1];
  always_ff @(posedge clk_i) begin
    if (rst_i) r_last <= 1'b1;
    else if (w_hs) r_last <= w_win;
  end
`else
  assign w_win = ~req_valid_i[0];
`endif
  assign w_hs = (r_state == IDLE) && |req_valid_i && !rst_i;
  assign req_ready_o = w_hs ? (w_win ? 2'b10 : 2'b01) : '0;
  assign w_partial = r_req.we && r_req.be != '1 && r_req.be != '0;
  dmem_be_merge u_merge (
    .i_old(r_old), .i_new(r_req.wdata), .i_be(r_req.be), .o_merged(w_merged)
  );
  always_comb begin
    w_next = IDLE;
    mem_write_en_o = 1'b0;
    mem_write_data_o = r_req.wdata;
    if (r_state == IDLE) w_next = w_hs ? ACCESS : IDLE;
    if (r_state == ACCESS) w_next = w_partial ? RMW_WRITE : IDLE;
    if (r_state == ACCESS) mem_write_en_o = r_req.we && r_req.be == '1;
    if (r_state == RMW_WRITE) mem_write_en_o = 1'b1;
    if (r_state == RMW_WRITE) mem_write_data_o = w_merged;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= IDLE;
      r_req   <= '0;
      r_grant <= 1'b0;
      r_old   <= '0;
      r_rdata <= '0;
      r_rsp   <= '0;
    end else begin
      r_state <= w_next;
      r_rsp   <= '0;
      if (w_hs) begin
        r_grant <= w_win;
        r_req   <= '{we: req_we_i[w_win], be: req_be_i[w_win],
                     addr: 32'(req_addr_i[w_win]), wdata: req_wdata_i[w_win]};
      end
      if (r_state == ACCESS) r_old <= mem_read_data_i;
      if (r_state == ACCESS && !w_partial) begin
        r_rsp[r_grant] <= 1'b1;
        r_rdata <= r_req.we ? '0 : mem_read_data_i;
      end
      if (r_state == RMW_WRITE) begin
        r_rsp[r_grant] <= 1'b1;
        r_rdata <= '0;
      end
    end
  end
  assign rsp_valid_o = r_rsp;
  assign rsp_rdata_o = r_rdata;
  assign mem_addr_o  = ADDR_WIDTH'(r_req.addr);
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed self-checking bench for dmem_arbiter with a falling-edge-write memory model.
module tb_dmem_arbiter;
  logic clk = 1'b0;
  logic rst;
  logic [1:0] valid, ready, we, rsp;
  logic [1:0][3:0] be;
  logic [1:0][31:0] addr, wdata;
  logic [31:0] rdata, m_addr, m_wdata, m_rdata;
  logic m_we;
  logic [31:0] mem [0:255];
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;
  assign m_rdata = mem[m_addr[9:2]];
  always @(negedge clk) if (m_we) mem[m_addr[9:2]] <= m_wdata;

  dmem_arbiter dut (
    .clk_i(clk), .rst_i(rst), .req_valid_i(valid), .req_ready_o(ready),
    .req_we_i(we), .req_be_i(be), .req_addr_i(addr), .req_wdata_i(wdata),
    .rsp_valid_o(rsp), .rsp_rdata_o(rdata), .mem_write_en_o(m_we),
    .mem_addr_o(m_addr), .mem_write_data_o(m_wdata), .mem_read_data_i(m_rdata)
  );

  task automatic step; @(posedge clk); #1; endtask
  task automatic smp; @(negedge clk); endtask

  task automatic test_reset;
    rst = 1'b1; valid = 2'b11; we = '0; be = '0; addr = '0; wdata = '0;
    step; step; smp;
    checks++; if (ready !== 2'b00) begin errors++; $display("FAIL rst_ready got=%b exp=00", ready); end
    checks++; if (rsp !== 2'b00) begin errors++; $display("FAIL rst_rsp got=%b exp=00", rsp); end
    checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL rst_rdata got=%h exp=0", rdata); end
    checks++; if (m_we !== 1'b0) begin errors++; $display("FAIL rst_we got=%b exp=0", m_we); end
    checks++; if (m_addr !== 32'h0) begin errors++; $display("FAIL rst_addr got=%h exp=0", m_addr); end
    checks++; if (m_wdata !== 32'h0) begin errors++; $display("FAIL rst_wdata got=%h exp=0", m_wdata); end
    step; rst = 1'b0; valid = 2'b00;
  endtask

  task automatic test_load;
    valid = 2'b01; we[0] = 1'b0; addr[0] = 32'h10000;
    smp;
    checks++; if (ready !== 2'b01) begin errors++; $display("FAIL load_ready got=%b exp=01", ready); end
    step; valid = 2'b00; smp;
    checks++; if (rsp !== 2'b00) begin errors++; $display("FAIL load_early_rsp got=%b exp=00", rsp); end
    checks++; if (m_addr !== 32'h10000) begin errors++; $display("FAIL load_addr got=%h exp=10000", m_addr); end
    step; smp;
    checks++; if (rsp !== 2'b01) begin errors++; $display("FAIL load_rsp got=%b exp=01", rsp); end
    checks++; if (rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL load_rdata got=%h exp=deadbeef", rdata); end
    step; smp;
    checks++; if (rsp !== 2'b00) begin errors++; $display("FAIL load_rsp_pulse got=%b exp=00", rsp); end
    step;
  endtask

  task automatic test_full_store;
    valid = 2'b10; we[1] = 1'b1; be[1] = 4'hF; addr[1] = 32'h10004; wdata[1] = 32'h12345678;
    smp;
    checks++; if (ready !== 2'b10) begin errors++; $display("FAIL fst_ready got=%b exp=10", ready); end
    step; valid = 2'b00; smp;
    checks++; if (m_we !== 1'b1) begin errors++; $display("FAIL fst_we got=%b exp=1", m_we); end
    checks++; if (m_wdata !== 32'h12345678) begin errors++; $display("FAIL fst_wdata got=%h exp=12345678", m_wdata); end
    step; smp;
    checks++; if (rsp !== 2'b10) begin errors++; $display("FAIL fst_rsp got=%b exp=10", rsp); end
    checks++; if (m_we !== 1'b0) begin errors++; $display("FAIL fst_we_once got=%b exp=0", m_we); end
    checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL fst_rdata got=%h exp=0", rdata); end
    step;
    valid = 2'b10; we[1] = 1'b0;
    smp; step; valid = 2'b00; smp;
    checks++; if (m_we !== 1'b0) begin errors++; $display("FAIL rb_we got=%b exp=0", m_we); end
    step; smp;
    checks++; if (rsp !== 2'b10) begin errors++; $display("FAIL rb_rsp got=%b exp=10", rsp); end
    checks++; if (rdata !== 32'h12345678) begin errors++; $display("FAIL rb_rdata got=%h exp=12345678", rdata); end
    step;
  endtask

  task automatic test_partial;
    valid = 2'b01; we[0] = 1'b1; be[0] = 4'b0010; addr[0] = 32'h10008; wdata[0] = 32'h0000AB00;
    smp; step; valid = 2'b00; smp;
    checks++; if (m_we !== 1'b0) begin errors++; $display("FAIL pst_acc_we got=%b exp=0", m_we); end
    checks++; if (rsp !== 2'b00) begin errors++; $display("FAIL pst_acc_rsp got=%b exp=00", rsp); end
    step; smp;
    checks++; if (m_we !== 1'b1) begin errors++; $display("FAIL pst_rmw_we got=%b exp=1", m_we); end
    checks++; if (m_wdata !== 32'h1122AB44) begin errors++; $display("FAIL pst_merge got=%h exp=1122ab44", m_wdata); end
    checks++; if (rsp !== 2'b00) begin errors++; $display("FAIL pst_rmw_rsp got=%b exp=00", rsp); end
    step; smp;
    checks++; if (rsp !== 2'b01) begin errors++; $display("FAIL pst_rsp got=%b exp=01", rsp); end
    checks++; if (m_we !== 1'b0) begin errors++; $display("FAIL pst_we_done got=%b exp=0", m_we); end
    step;
    checks++; if (mem[2] !== 32'h1122AB44) begin errors++; $display("FAIL pst_mem got=%h exp=1122ab44", mem[2]); end
  endtask

  task automatic test_be_zero;
    valid = 2'b10; we[1] = 1'b1; be[1] = 4'h0; addr[1] = 32'h1000C; wdata[1] = 32'hFFFFFFFF;
    smp; step; valid = 2'b00; smp;
    checks++; if (m_we !== 1'b0) begin errors++; $display("FAIL bez_we got=%b exp=0", m_we); end
    step; smp;
    checks++; if (rsp !== 2'b10) begin errors++; $display("FAIL bez_rsp got=%b exp=10", rsp); end
    checks++; if (m_we !== 1'b0) begin errors++; $display("FAIL bez_we2 got=%b exp=0", m_we); end
    step;
    checks++; if (mem[3] !== 32'h55667788) begin errors++; $display("FAIL bez_mem got=%h exp=55667788", mem[3]); end
  endtask

  task automatic test_arb;
    logic [1:0] exp, prev;
    prev = 2'b00;
    valid = 2'b11; we = 2'b00; addr[0] = 32'h10000; addr[1] = 32'h10000;
    for (int i = 0; i < 4; i++) begin
`ifdef DMEM_ARB_RR_EN
      exp = (i % 2 == 0) ? 2'b01 : 2'b10;
`else
      exp = 2'b01;
`endif
      smp;
      if (i > 0) begin
        checks++; if (rsp !== prev) begin errors++; $display("FAIL arb_rsp%0d got=%b exp=%b", i, rsp, prev); end
      end
      checks++; if (ready !== exp) begin errors++; $display("FAIL arb_ready%0d got=%b exp=%b", i, ready, exp); end
      step; step;
      prev = exp;
    end
    smp;
    checks++; if (rsp !== prev) begin errors++; $display("FAIL arb_rsp_last got=%b exp=%b", rsp, prev); end
    valid = 2'b00;
    step;
  endtask

  task automatic test_reset_mid;
    valid = 2'b01; we[0] = 1'b1; be[0] = 4'b0001; addr[0] = 32'h10008; wdata[0] = 32'h000000CC;
    smp; step; valid = 2'b00; smp; step; smp;
    checks++; if (m_we !== 1'b1) begin errors++; $display("FAIL rm_rmw_we got=%b exp=1", m_we); end
    rst = 1'b1;
    step; rst = 1'b0; valid = 2'b01; smp;
    checks++; if (m_we !== 1'b0) begin errors++; $display("FAIL rm_we got=%b exp=0", m_we); end
    checks++; if (rsp !== 2'b00) begin errors++; $display("FAIL rm_rsp got=%b exp=00", rsp); end
    checks++; if (ready !== 2'b01) begin errors++; $display("FAIL rm_idle_ready got=%b exp=01", ready); end
    checks++; if (m_addr !== 32'h0) begin errors++; $display("FAIL rm_addr got=%h exp=0", m_addr); end
    valid = 2'b00;
    step; smp;
    checks++; if (rsp !== 2'b00) begin errors++; $display("FAIL rm_rsp2 got=%b exp=00", rsp); end
    step;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[0] = 32'hDEADBEEF;
    mem[2] = 32'h11223344;
    mem[3] = 32'h55667788;
    test_reset;
    test_load;
    test_full_store;
    test_partial;
    test_be_zero;
    test_arb;
    test_reset_mid;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
